// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 20-bit ALU execution responder with zero/sign/carry status.
// One request is taken in IDLE, its result is registered, and the result is then
// offered on the response side until it is consumed.
// Optional build macro ALU_EXEC_MUL_EN adds opcode 22 (iterative shift-add MUL)
// and the BUSY state; without it opcode 22 is reported as illegal.
//
// Handshakes: a request transfers on the rising edge where req_valid & req_ready;
// a response transfers on the rising edge where rsp_valid & rsp_ready, and while
// rsp_valid is high rsp_c/rsp_c2/rsp_err stay stable.
module alu_exec_unit #(
  parameter int WIDTH = 20,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic [WIDTH-1:0] rsp_c2,
  output logic             rsp_err,
  output logic             status_zero,
  output logic             status_sign,
  output logic             status_carry
);
  localparam int HALF = WIDTH / 2;

  localparam logic [OPW-1:0] OP_NOT   = OPW'(0);
  localparam logic [OPW-1:0] OP_AND   = OPW'(1);
  localparam logic [OPW-1:0] OP_OR    = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(3);
  localparam logic [OPW-1:0] OP_SHR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL   = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ROL   = OPW'(7);
  localparam logic [OPW-1:0] OP_SWAP  = OPW'(8);
  localparam logic [OPW-1:0] OP_INC   = OPW'(9);
  localparam logic [OPW-1:0] OP_DEC   = OPW'(10);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(11);
  localparam logic [OPW-1:0] OP_ADC   = OPW'(12);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(13);
  localparam logic [OPW-1:0] OP_SBC   = OPW'(14);
  localparam logic [OPW-1:0] OP_EQ    = OPW'(15);
  localparam logic [OPW-1:0] OP_GT    = OPW'(16);
  localparam logic [OPW-1:0] OP_LT    = OPW'(17);
  localparam logic [OPW-1:0] OP_GE    = OPW'(18);
  localparam logic [OPW-1:0] OP_LE    = OPW'(19);
  localparam logic [OPW-1:0] OP_LDSR  = OPW'(20);
  localparam logic [OPW-1:0] OP_XORSR = OPW'(21);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t state, state_nx;

  logic             accept, is_mul, full_w, cin, err, zs_upd;
  logic             z_n, s_n, c_n;
  logic [WIDTH-1:0] res_mask, a_m, b_m, res, res2, res_m;
  logic [WIDTH:0]   sum;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = (state == S_IDLE) && req_valid;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = OPW'(22);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_acc_nx;
  logic [WIDTH-1:0]   mul_mplier, mul_lo;
  logic [CW-1:0]      mul_cnt;
  logic               mul_full, mul_done, mul_hi_nz, mul_sign;

  assign is_mul   = (req_op == OP_MUL);
  assign mul_done = (state == S_BUSY) && (mul_cnt == CW'(1));

  // One shift-add step; the final step's value is what gets reported.
  always_comb begin
    mul_acc_nx = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    mul_lo     = mul_full ? mul_acc_nx[WIDTH-1:0]
                          : {{(WIDTH-HALF){1'b0}}, mul_acc_nx[HALF-1:0]};
    mul_hi_nz  = mul_full ? (|mul_acc_nx[2*WIDTH-1:WIDTH]) : (|mul_acc_nx[WIDTH-1:HALF]);
    mul_sign   = mul_full ? mul_lo[WIDTH-1] : mul_lo[HALF-1];
  end

  // Multiplier registers: load on accept, then one step per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_full   <= 1'b0;
    end else if (accept && is_mul) begin
      mul_acc    <= '0;
      mul_mcand  <= {{WIDTH{1'b0}}, a_m};
      mul_mplier <= b_m;
      mul_cnt    <= req_mode ? CW'(WIDTH) : CW'(HALF);
      mul_full   <= req_mode;
    end else if (state == S_BUSY) begin
      mul_acc    <= mul_acc_nx;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt - CW'(1);
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle result and next status for the presented request.
  always_comb begin
    full_w   = req_mode || (req_op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_LDSR, OP_XORSR});
    res_mask = full_w ? {WIDTH{1'b1}} : {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
    a_m      = req_a & res_mask;
    b_m      = req_b & res_mask;
    cin      = ((req_op == OP_ADC) || (req_op == OP_SBC)) && status_carry;
    sum      = '0;
    res      = '0;
    res2     = '0;
    err      = 1'b0;
    zs_upd   = 1'b0;
    z_n      = status_zero;
    s_n      = status_sign;
    c_n      = status_carry;
    case (req_op)
      OP_NOT:   begin res = ~a_m;      zs_upd = 1'b1; end
      OP_AND:   begin res = a_m & b_m; zs_upd = 1'b1; end
      OP_OR:    begin res = a_m | b_m; zs_upd = 1'b1; end
      OP_XOR:   begin res = a_m ^ b_m; zs_upd = 1'b1; end
      OP_SHR:   begin res = req_a >> 1; c_n = req_a[0];       zs_upd = 1'b1; end
      OP_SHL:   begin res = req_a << 1; c_n = req_a[WIDTH-1]; zs_upd = 1'b1; end
      OP_ROR:   begin res = {req_a[0], req_a[WIDTH-1:1]};     zs_upd = 1'b1; end
      OP_ROL:   begin res = {req_a[WIDTH-2:0], req_a[WIDTH-1]}; zs_upd = 1'b1; end
      OP_SWAP:  begin res = b_m; res2 = a_m; end
      OP_INC:   begin
        sum = {1'b0, a_m} + (WIDTH+1)'(1);
        res = sum[WIDTH-1:0]; c_n = (a_m == res_mask); zs_upd = 1'b1;
      end
      OP_DEC:   begin
        sum = {1'b0, a_m} - (WIDTH+1)'(1);
        res = sum[WIDTH-1:0]; c_n = (a_m == '0); zs_upd = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a_m} + {1'b0, b_m} + (WIDTH+1)'(cin);
        res = sum[WIDTH-1:0]; c_n = full_w ? sum[WIDTH] : sum[HALF]; zs_upd = 1'b1;
      end
      OP_SUB, OP_SBC: begin
        // Operands are masked, so a negative difference always sets the top bit.
        sum = {1'b0, a_m} - {1'b0, b_m} - (WIDTH+1)'(cin);
        res = sum[WIDTH-1:0]; c_n = sum[WIDTH]; zs_upd = 1'b1;
      end
      OP_EQ:    z_n = (a_m == b_m);
      OP_GT:    s_n = (a_m > b_m);
      OP_LT:    s_n = (a_m < b_m);
      OP_GE:    begin s_n = (a_m >= b_m); z_n = (a_m == b_m); end
      OP_LE:    begin s_n = (a_m <= b_m); z_n = (a_m == b_m); end
      OP_LDSR:  {c_n, s_n, z_n} = req_a[2:0];
      OP_XORSR: {c_n, s_n, z_n} = {status_carry, status_sign, status_zero} ^ req_a[2:0];
`ifdef ALU_EXEC_MUL_EN
      OP_MUL:   begin end
`endif
      default:  err = 1'b1;
    endcase
    res_m = res & res_mask;
    if (zs_upd) begin
      z_n = (res_m == '0);
      s_n = full_w ? res_m[WIDTH-1] : res_m[HALF-1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
`ifdef ALU_EXEC_MUL_EN
        state_nx = is_mul ? S_BUSY : S_RESP;
`else
        state_nx = S_RESP;
`endif
      end
`ifdef ALU_EXEC_MUL_EN
      S_BUSY: if (mul_done) state_nx = S_RESP;
`endif
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Response and status registers, written when a result is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_c        <= '0;
      rsp_c2       <= '0;
      rsp_err      <= 1'b0;
      status_zero  <= 1'b0;
      status_sign  <= 1'b0;
      status_carry <= 1'b0;
    end else if (accept && !is_mul) begin
      rsp_c        <= res_m;
      rsp_c2       <= res2;
      rsp_err      <= err;
      status_zero  <= z_n;
      status_sign  <= s_n;
      status_carry <= c_n;
    end
`ifdef ALU_EXEC_MUL_EN
    else if (mul_done) begin
      rsp_c        <= mul_lo;
      rsp_c2       <= '0;
      rsp_err      <= 1'b0;
      status_zero  <= (mul_lo == '0);
      status_sign  <= mul_sign;
      status_carry <= mul_hi_nz;
    end
`endif
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execution responder for the 20-bit ALU datapath.
- Accepts one operation per request handshake, computes the result, and returns it through a response handshake.
- Keeps the architectural status register (zero/sign/carry) that the program-flow logic (jumps, LDSR/XORSR) consumes.
- Sits between instruction decode (initiator) and register writeback.

Parameters:
- WIDTH, 20, full-word datapath width; must be even. Half-word width HALF = WIDTH/2.
- OPW, 5, opcode field width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_op  input  OPW  opcode.
- req_mode  input  1  1 = full-word, 0 = half-word.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_c  output  WIDTH  primary result.
- rsp_c2  output  WIDTH  secondary result; SWAP only, 0 otherwise.
- rsp_err  output  1  illegal opcode flag, valid with rsp_valid.
- status_zero / status_sign / status_carry  output  1 each  status register bits.

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0 except req_ready=1; status = 000.
- FSM states IDLE, BUSY, RESP.
  - IDLE -> RESP on req_valid&req_ready. Result, rsp_err and status are registered at the accepting edge, so rsp_valid is high the next cycle. Latency is 1 cycle.
  - IDLE -> BUSY applies to MUL only (see Optional Feature).
  - RESP: rsp_valid=1, and rsp_c/rsp_c2/rsp_err are held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE. req_valid is ignored outside IDLE. Throughput is 1 op per 2 cycles.
- Half mode: operands masked to [HALF-1:0]; result bits [WIDTH-1:HALF] forced to 0. Active width is W = HALF or WIDTH.
- Flags, unless stated otherwise: zero = (result[W-1:0]==0); sign = result[W-1].
- Opcodes:
  - Logic ops, carry unchanged: 0 NOT, 1 AND, 2 OR, 3 XOR.
  - 4 SHR, 5 SHL: carry = bit shifted out. These ignore req_mode and always use full width.
  - 6 ROR, 7 ROL: full width; zero/sign updated, carry unchanged.
  - 8 SWAP: rsp_c=b, rsp_c2=a; flags unchanged.
  - 9 INC: carry = wrap from all-ones.
  - 10 DEC: carry = borrow when a==0.
  - 11 ADD: carry = carry-out of bit W-1.
  - 12 ADC: a+b+status_carry.
  - 13 SUB: carry = borrow (a<b unsigned).
  - 14 SBC: a-b-status_carry.
  - Compares, unsigned on the masked operands; rsp_c=0, carry unchanged:
    - 15 EQ: zero = (a==b).
    - 16 GT: sign = (a>b).
    - 17 LT: sign = (a<b).
    - 18 GE: sign = (a>=b), zero = (a==b).
    - 19 LE: sign = (a<=b), zero = (a==b).
  - Status register ops (req_mode ignored, rsp_c=0). Bit order {carry,sign,zero} = a[2:0]:
    - 20 LDSR: status <= a[2:0].
    - 21 XORSR: status <= status ^ a[2:0].
  - Any other opcode (including 22 when the macro is absent): rsp_err=1, rsp_c=rsp_c2=0, status unchanged.
- Flags not listed for an op retain their value.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
- Defined: opcode 22 MUL is a shift-add iterative multiply.
  - IDLE -> BUSY on accept. BUSY runs exactly W cycles (20 full, 10 half), then goes to RESP.
  - rsp_c = low W bits of the product.
  - carry = (high W product bits != 0); zero/sign from rsp_c.
  - Async reset in BUSY aborts to IDLE with no status update.
- Undefined: no BUSY state logic; opcode 22 is illegal (rsp_err=1).

Test Plan:
- ADD full, a=0xFFFFF, b=0x00001 -> rsp_valid exactly 1 cycle after accept; rsp_c=0x00000; zero=1, sign=0, carry=1.
- Status carry=1, then ADC half, a=0x12005, b=0x00003 -> rsp_c=0x00009, carry=0, zero=0.
- SHR a=0x00003 -> rsp_c=0x00001, carry=1; SWAP a=0x0000A, b=0x00005 -> rsp_c=0x00005, rsp_c2=0x0000A, flags unchanged.
- Hold rsp_ready=0 for 5 cycles after an op -> rsp_valid=1, rsp_c stable, req_ready=0, and a competing req_valid is not accepted. Release -> IDLE next cycle.
- LDSR a=0x5 -> carry=1, sign=0, zero=1. Then XORSR a=0x7 -> carry=0, sign=1, zero=0. Then LT full, a=3, b=9 -> sign=1.
- Opcode 31 -> rsp_err=1, rsp_c=0, status unchanged.
- Assert rst during RESP -> rsp_valid=0 and status=000 immediately, with no clock edge needed.
- With ALU_EXEC_MUL_EN: MUL full, 0x00400 × 0x00400 -> 20 BUSY cycles, rsp_c=0x00000, carry=1, zero=1.
